// File: rtl/fp_norm_shift_pipe_if.sv
// ============================================================================
// Module  : fp_norm_shift_pipe_if
// Purpose : Handshake and data bundle between the adder, the normalizer and
//           the rounding stage.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface fp_norm_shift_pipe_if #(
  parameter int MW = 32,
  parameter int EW = 8
);
  logic          InValid;
  logic          InReady;
  logic [MW-1:0] Sum;
  logic [EW-1:0] Exp;
  logic          OutValid;
  logic          OutReady;
  logic [MW-1:0] Mnorm;
  logic [EW-1:0] ExpNorm;
  logic [4:0]    NormShift;
  logic          Zero;
  logic          Underflow;

  modport master (
    output InValid, Sum, Exp, OutReady,
    input  InReady, OutValid, Mnorm, ExpNorm, NormShift, Zero, Underflow
  );

  modport slave (
    input  InValid, Sum, Exp, OutReady,
    output InReady, OutValid, Mnorm, ExpNorm, NormShift, Zero, Underflow
  );
endinterface

`default_nettype wire

// File: rtl/fp_norm_shift_pipe.sv
// ============================================================================
// Module  : fp_norm_shift_pipe
// Purpose : Two-stage post-add normalizer: coarse left shift (16|12|8|4), then
//           fine shift (3|2|1), exponent clamped at zero (denormal result).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module fp_norm_shift_pipe #(
  parameter int MW = 32,
  parameter int EW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_norm_shift_pipe_if.slave  bus
);

  // Stage-1 combinational analysis
  logic [5:0]    lzc;
  logic          sum_nz;
  logic          under;
  logic [4:0]    s_amt;
  logic [MW-1:0] m16;
  logic [MW-1:0] m_coarse;
  logic [EW-1:0] exp_norm;

  // Handshake
  logic load2;
  logic load1;

  // Stage 1 registers
  logic          s1_valid_q, s1_valid_d;
  logic [MW-1:0] s1_mant_q,  s1_mant_d;
  logic [4:0]    s1_s_q,     s1_s_d;
  logic [EW-1:0] s1_exp_q,   s1_exp_d;
  logic          s1_zero_q,  s1_zero_d;
  logic          s1_unf_q,   s1_unf_d;

  // Stage 2 (output) registers
  logic          out_valid_q, out_valid_d;
  logic [MW-1:0] mnorm_q,     mnorm_d;
  logic [4:0]    nshift_q,    nshift_d;
  logic [EW-1:0] exp_norm_q,  exp_norm_d;
  logic          zero_q,      zero_d;
  logic          unf_q,       unf_d;

  // Scanning up from the LSB leaves the count for the highest set bit.
  always_comb begin
    lzc = 6'd32;
    for (int i = 0; i < MW; i++) begin
      if (bus.Sum[i]) lzc = 6'(MW - 1 - i);
    end
  end

  // When the floor limits the shift, Exp < LZC <= 31, so Exp fits in 5 bits.
  always_comb begin
    sum_nz   = |bus.Sum;
    under    = sum_nz && (32'(lzc) > 32'(bus.Exp));
    s_amt    = !sum_nz ? 5'd0 : (under ? bus.Exp[4:0] : lzc[4:0]);
    exp_norm = !sum_nz ? '0 : (bus.Exp - EW'(s_amt));
    m16      = s_amt[4] ? (bus.Sum << 16) : bus.Sum;
    m_coarse = m16 << {s_amt[3:2], 2'b00};
  end

  assign load2       = !out_valid_q || bus.OutReady;
  assign load1       = !s1_valid_q || load2;
  assign bus.InReady = load1;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mant_d  = s1_mant_q;
    s1_s_d     = s1_s_q;
    s1_exp_d   = s1_exp_q;
    s1_zero_d  = s1_zero_q;
    s1_unf_d   = s1_unf_q;
    if (load1) begin
      s1_valid_d = bus.InValid;
      if (bus.InValid) begin
        s1_mant_d = m_coarse;
        s1_s_d    = s_amt;
        s1_exp_d  = exp_norm;
        s1_zero_d = !sum_nz;
        s1_unf_d  = under;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    mnorm_d     = mnorm_q;
    nshift_d    = nshift_q;
    exp_norm_d  = exp_norm_q;
    zero_d      = zero_q;
    unf_d       = unf_q;
    if (load2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        mnorm_d    = s1_mant_q << s1_s_q[1:0];
        nshift_d   = s1_s_q;
        exp_norm_d = s1_exp_q;
        zero_d     = s1_zero_q;
        unf_d      = s1_unf_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mant_q   <= '0;
      s1_s_q      <= '0;
      s1_exp_q    <= '0;
      s1_zero_q   <= 1'b0;
      s1_unf_q    <= 1'b0;
      out_valid_q <= 1'b0;
      mnorm_q     <= '0;
      nshift_q    <= '0;
      exp_norm_q  <= '0;
      zero_q      <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mant_q   <= s1_mant_d;
      s1_s_q      <= s1_s_d;
      s1_exp_q    <= s1_exp_d;
      s1_zero_q   <= s1_zero_d;
      s1_unf_q    <= s1_unf_d;
      out_valid_q <= out_valid_d;
      mnorm_q     <= mnorm_d;
      nshift_q    <= nshift_d;
      exp_norm_q  <= exp_norm_d;
      zero_q      <= zero_d;
      unf_q       <= unf_d;
    end
  end

  assign bus.OutValid  = out_valid_q;
  assign bus.Mnorm     = mnorm_q;
  assign bus.NormShift = nshift_q;
  assign bus.ExpNorm   = exp_norm_q;
  assign bus.Zero      = zero_q;
  assign bus.Underflow = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_norm_shift_pipe.sv
// ============================================================================
// Module  : tb_fp_norm_shift_pipe
// Purpose : Directed vector table plus handshake, backpressure and reset
//           sequences for the normalizer pipeline.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_fp_norm_shift_pipe;

  typedef struct {
    logic [31:0] sum;
    logic [7:0]  exp;
    logic [31:0] mn;
    logic [7:0]  en;
    logic [4:0]  ns;
    logic        z;
    logic        u;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fp_norm_shift_pipe_if #(.MW(32), .EW(8)) bus ();

  fp_norm_shift_pipe #(.MW(32), .EW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_out(input string tag, input vec_t v);
    chk({tag, ".Mnorm"},     bus.Mnorm,            v.mn);
    chk({tag, ".ExpNorm"},   32'(bus.ExpNorm),     32'(v.en));
    chk({tag, ".NormShift"}, 32'(bus.NormShift),   32'(v.ns));
    chk({tag, ".Zero"},      32'(bus.Zero),        32'(v.z));
    chk({tag, ".Underflow"}, 32'(bus.Underflow),   32'(v.u));
  endtask

  // One isolated transfer; result must appear exactly two edges later.
  task automatic run_vec(input string tag, input vec_t v);
    @(negedge clk);
    bus.InValid = 1'b1;
    bus.Sum     = v.sum;
    bus.Exp     = v.exp;
    chk({tag, ".InReady"}, 32'(bus.InReady), 32'd1);
    @(negedge clk);
    bus.InValid = 1'b0;
    chk({tag, ".early_valid"}, 32'(bus.OutValid), 32'd0);
    @(negedge clk);
    chk({tag, ".OutValid"}, 32'(bus.OutValid), 32'd1);
    chk_out(tag, v);
  endtask

  vec_t tbl[10];
  vec_t bp[3];
  vec_t q[$];
  int   out_cyc[$];
  int   out_ns[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            sum           exp     Mnorm         ExpNorm NS     Z     U
    tbl[0] = '{32'h0000_0001, 8'd40,  32'h8000_0000, 8'd9,   5'd31, 1'b0, 1'b0};
    tbl[1] = '{32'h0001_2345, 8'd5,   32'h0024_68A0, 8'd0,   5'd5,  1'b0, 1'b1};
    tbl[2] = '{32'h0000_0000, 8'd100, 32'h0000_0000, 8'd0,   5'd0,  1'b1, 1'b0};
    tbl[3] = '{32'h8000_0000, 8'd0,   32'h8000_0000, 8'd0,   5'd0,  1'b0, 1'b0};
    tbl[4] = '{32'h0000_0001, 8'd0,   32'h0000_0001, 8'd0,   5'd0,  1'b0, 1'b1};
    tbl[5] = '{32'h0000_F000, 8'd200, 32'hF000_0000, 8'd184, 5'd16, 1'b0, 1'b0};
    tbl[6] = '{32'h0000_0800, 8'd255, 32'h8000_0000, 8'd235, 5'd20, 1'b0, 1'b0};
    tbl[7] = '{32'h0070_0000, 8'd9,   32'hE000_0000, 8'd0,   5'd9,  1'b0, 1'b0};
    tbl[8] = '{32'h0000_0003, 8'd30,  32'hC000_0000, 8'd0,   5'd30, 1'b0, 1'b0};
    tbl[9] = '{32'h0000_0003, 8'd29,  32'h6000_0000, 8'd0,   5'd29, 1'b0, 1'b1};

    bp[0]  = '{32'h0001_0000, 8'd100, 32'h8000_0000, 8'd85,  5'd15, 1'b0, 1'b0};
    bp[1]  = '{32'h1234_5678, 8'd3,   32'h91A2_B3C0, 8'd0,   5'd3,  1'b0, 1'b0};
    bp[2]  = '{32'h0000_000F, 8'd10,  32'h0000_3C00, 8'd0,   5'd10, 1'b0, 1'b1};

    bus.InValid  = 1'b0;
    bus.Sum      = '0;
    bus.Exp      = '0;
    bus.OutReady = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.OutValid", 32'(bus.OutValid), 32'd0);
    chk("rst.InReady",  32'(bus.InReady),  32'd1);
    chk_out("rst", '{32'h0, 8'd0, 32'h0, 8'd0, 5'd0, 1'b0, 1'b0});
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // Back-to-back, OutReady high: results on consecutive cycles
    @(negedge clk);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.OutValid) begin
        out_cyc.push_back(c);
        out_ns.push_back(int'(bus.NormShift));
      end
      bus.InValid = (c < 3);
      bus.Exp     = 8'd20;
      case (c)
        0:       bus.Sum = 32'h8000_0000;
        1:       bus.Sum = 32'h4000_0000;
        default: bus.Sum = 32'h0800_0000;
      endcase
    end
    bus.InValid = 1'b0;
    chk("b2b.count", 32'(out_cyc.size()), 32'd3);
    if (out_cyc.size() == 3) begin
      chk("b2b.first_cycle", 32'(out_cyc[0]), 32'd2);
      chk("b2b.consec1",     32'(out_cyc[1]), 32'd3);
      chk("b2b.consec2",     32'(out_cyc[2]), 32'd4);
      chk("b2b.ns0",         32'(out_ns[0]),  32'd0);
      chk("b2b.ns1",         32'(out_ns[1]),  32'd1);
      chk("b2b.ns2",         32'(out_ns[2]),  32'd4);
    end

    // Backpressure: OutReady low for 4 cycles, 3 inputs offered
    begin
      int sent;
      int got;
      sent = 0;
      got  = 0;
      q    = {bp[0], bp[1], bp[2]};
      for (int c = 0; c < 20 && got < 3; c++) begin
        @(negedge clk);
        bus.OutReady = (c >= 4);
        if (bus.OutValid) begin
          chk_out(bus.OutReady ? "bp.out" : "bp.hold", q[0]);
          if (bus.OutReady) begin
            void'(q.pop_front());
            got++;
          end
        end
        if (sent < 3) begin
          bus.InValid = 1'b1;
          bus.Sum     = bp[sent].sum;
          bus.Exp     = bp[sent].exp;
        end else begin
          bus.InValid = 1'b0;
        end
        #1;
        if (c == 3) begin
          chk("bp.InReady_low", 32'(bus.InReady), 32'd0);
          chk("bp.accepted",    32'(sent),        32'd2);
        end
        if (bus.InValid && bus.InReady) sent++;
      end
      bus.InValid = 1'b0;
      chk("bp.all_out", 32'(got), 32'd3);
    end

    // Reset with two items in flight
    @(negedge clk);
    bus.OutReady = 1'b0;
    bus.InValid  = 1'b1;
    bus.Sum      = 32'h0000_00FF;
    bus.Exp      = 8'd50;
    @(negedge clk);
    bus.Sum      = 32'h00FF_0000;
    @(negedge clk);
    bus.InValid  = 1'b0;
    chk("rsti.OutValid_before", 32'(bus.OutValid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rsti.OutValid_async", 32'(bus.OutValid), 32'd0);
    chk("rsti.InReady",        32'(bus.InReady),  32'd1);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.OutReady = 1'b1;
    begin
      int ghosts;
      ghosts = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (bus.OutValid) ghosts++;
      end
      chk("rsti.no_emit", 32'(ghosts), 32'd0);
    end
    run_vec("rsti.recover", tbl[1]);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
